vec_mem_unit: RTL



---
 rtl/vec_mem_unit_pkg.sv | 26 ++
 rtl/vec_mem_unit_if.sv | 26 ++
 rtl/vec_mem_unit_addr_gen.sv | 49 ++++
 rtl/vec_mem_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/vec_mem_unit_pkg.sv
// Shared constants, FSM state type and lane helper for the vector memory unit.
package vec_pkg;
  localparam int LANES   = 8;
  localparam int ADDR_W  = 15;
  localparam int DATA_W  = 64;
  localparam int MEM_TOP = 24576;
  localparam int LEN_W   = 4;
  localparam int IDX_W   = $clog2(LANES);
  localparam int VEC_W   = LANES * DATA_W;

  localparam logic [ADDR_W-1:0] MEM_TOP_A = ADDR_W'(MEM_TOP);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_STORE,
    ST_DONE
  } vec_state_e;

  // Extract element i from a lane-packed vector.
  function automatic logic [DATA_W-1:0] lane_get(input logic [VEC_W-1:0] v,
                                                  input logic [IDX_W-1:0] i);
    return v[i*DATA_W +: DATA_W];
  endfunction
endpackage

// File: rtl/vec_mem_unit_if.sv
// Request/response bundle between a requester and the vector memory unit.
interface vec_mem_unit_if;
  import vec_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic              req_flush;
  logic [ADDR_W-1:0] req_base;
  logic [ADDR_W-1:0] req_stride;
  logic [LEN_W-1:0]  req_len;
  logic [VEC_W-1:0]  st_data;
  logic              done;
  logic              err;
  logic [VEC_W-1:0]  ld_data;

  modport master (
    output req_valid, req_store, req_flush, req_base, req_stride, req_len, st_data,
    input  req_ready, done, err, ld_data
  );

  modport slave (
    input  req_valid, req_store, req_flush, req_base, req_stride, req_len, st_data,
    output req_ready, done, err, ld_data
  );
endinterface

// File: rtl/vec_mem_unit_addr_gen.sv
// Element address accumulator and element counter. The accumulator register
// drives the memory address directly, so it is cleared to 0 between requests.
module vec_addr_gen
  import vec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              clear,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  idx,
  output logic              last,
  output logic              oob
);

  logic [ADDR_W-1:0] acc_q;
  logic [ADDR_W-1:0] acc_step;
  logic [IDX_W-1:0]  cnt_q;
  logic              oob_q;

  assign acc_step = acc_q + stride;

  // Address/counter registers; range flag is registered alongside the address.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_q <= '0;
      cnt_q <= '0;
      oob_q <= 1'b0;
    end else if (load) begin
      acc_q <= base;
      cnt_q <= '0;
      oob_q <= base > MEM_TOP_A;
    end else if (step) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q + IDX_W'(1);
      oob_q <= acc_step > MEM_TOP_A;
    end
  end

  assign addr = acc_q;
  assign idx  = cnt_q;
  assign oob  = oob_q;
  assign last = LEN_W'(cnt_q) == (len - LEN_W'(1));

endmodule

// File: rtl/vec_mem_unit.sv
// Vector load/store sequencer in front of dmem: one element access per cycle,
// load results assembled into a lane-packed vector.
//
// state | meaning
// IDLE  | ready for a request
// LOAD  | issuing one read address per cycle
// DRAIN | capturing the final read word
// STORE | writing one element per cycle
// DONE  | one-cycle completion pulse
module vec_mem_unit
  import vec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  vec_mem_unit_if.slave     bus,
  output logic [ADDR_W-1:0] mem_dir,
  output logic              mem_write_flag,
  output logic              mem_file_enable,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  vec_state_e        state;
  logic              ready_q, done_q, err_q;
  logic [VEC_W-1:0]  ld_q, stage_q, stage_nxt, st_q;
  logic [ADDR_W-1:0] stride_q;
  logic [LEN_W-1:0]  len_q, len_c;
  logic              flush_q, wr_q, fe_q;
  logic [DATA_W-1:0] din_q;
  logic              cap_v, cap_oob;
  logic [IDX_W-1:0]  cap_idx;

  logic              gen_load, gen_step, gen_clear;
  logic [ADDR_W-1:0] gen_addr;
  logic [IDX_W-1:0]  gen_idx;
  logic              gen_last, gen_oob;

  assign len_c = (bus.req_len > LEN_W'(LANES)) ? LEN_W'(LANES) : bus.req_len;

  vec_addr_gen u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .load   (gen_load),
    .step   (gen_step),
    .clear  (gen_clear),
    .base   (bus.req_base),
    .stride (stride_q),
    .len    (len_q),
    .addr   (gen_addr),
    .idx    (gen_idx),
    .last   (gen_last),
    .oob    (gen_oob)
  );

  // Address generator control: load on accept, advance per element, clear after the last.
  always_comb begin
    gen_load  = 1'b0;
    gen_step  = 1'b0;
    gen_clear = 1'b0;
    case (state)
      ST_IDLE:           gen_load = bus.req_valid && (len_c != '0);
      ST_LOAD, ST_STORE: begin
        if (gen_last) gen_clear = 1'b1;
        else          gen_step  = 1'b1;
      end
      default: ;
    endcase
  end

  // Merge the word returning from dmem into the staging vector.
  always_comb begin
    stage_nxt = stage_q;
    if (cap_v) stage_nxt[cap_idx*DATA_W +: DATA_W] = cap_oob ? '0 : mem_data_out;
  end

  // Sequencer FSM with registered handshake and memory-control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ld_q     <= '0;
      stage_q  <= '0;
      st_q     <= '0;
      stride_q <= '0;
      len_q    <= '0;
      flush_q  <= 1'b0;
      wr_q     <= 1'b0;
      fe_q     <= 1'b0;
      din_q    <= '0;
      cap_v    <= 1'b0;
      cap_idx  <= '0;
      cap_oob  <= 1'b0;
    end else begin
      cap_v <= 1'b0;
      if (cap_v) stage_q <= stage_nxt;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            stride_q <= bus.req_stride;
            len_q    <= len_c;
            flush_q  <= bus.req_flush;
            st_q     <= bus.st_data;
            if (len_c == '0) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
              if (!bus.req_store) ld_q <= '0;
            end else if (bus.req_store) begin
              state <= ST_STORE;
              wr_q  <= 1'b1;
              din_q <= lane_get(bus.st_data, '0);
              fe_q  <= bus.req_flush && (len_c == LEN_W'(1));
            end else begin
              state   <= ST_LOAD;
              stage_q <= '0;
            end
          end
        end
        ST_LOAD: begin
          cap_v   <= 1'b1;
          cap_idx <= gen_idx;
          cap_oob <= gen_oob;
          if (gen_oob)  err_q <= 1'b1;
          if (gen_last) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          ld_q   <= stage_nxt;
          done_q <= 1'b1;
          state  <= ST_DONE;
        end
        ST_STORE: begin
          if (gen_oob) err_q <= 1'b1;
          if (gen_last) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
            wr_q   <= 1'b0;
            fe_q   <= 1'b0;
            din_q  <= '0;
          end else begin
            din_q <= lane_get(st_q, gen_idx + IDX_W'(1));
            fe_q  <= flush_q && ((LEN_W'(gen_idx) + LEN_W'(2)) == len_q);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.ld_data     = ld_q;
  assign mem_dir         = gen_addr;
  assign mem_write_flag  = wr_q & ~gen_oob;
  assign mem_file_enable = fe_q;
  assign mem_data_in     = din_q;

endmodule
